// File: rtl/pipe_result_collector.sv
// Result collector for the F = ((A+B)+(C-D))*D pipeline.
// Tracks valid slots, buffers results in a FIFO, keeps a running sum.
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  parameter int SUMW  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [N-1:0]             F,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [N-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SUMW-1:0]          sum,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LAT-1:0]  v_q, v_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic            ovf_q, ovf_d;
  logic [N-1:0]    mem_q [DEPTH];

  logic push, pop, accept, full, empty;

  assign push   = v_q[LAT-1];
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = !empty && out_ready;
  // A pop in the same edge frees the slot the push needs.
  assign accept = push && (!full || pop);

  always_comb begin
    v_d      = v_q << 1;
    v_d[0]   = in_valid;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      sum_d    = sum_q + SUMW'(F);
    end
    if (push && !accept) begin
      ovf_d = 1'b1;
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      v_q      <= v_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= F;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Bench for pipe_result_collector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pipe_result_collector;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int SUMW  = 18;
  localparam int HMAX  = 4096;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [N-1:0]    F;
  logic            out_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [2:0]      count;
  logic [SUMW-1:0] sum;
  logic            overflow;

  int checks;
  int errors;

  pipe_result_collector #(
    .N(N), .DEPTH(DEPTH), .LAT(3), .SUMW(SUMW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .F(F),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .count(count), .sum(sum),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-edge history: slot c is the cycle ending at edge c.
  bit           hv   [HMAX];
  bit           hrst [HMAX];
  logic [N-1:0] hr   [HMAX];
  int           cyc;

  logic [N-1:0]    mq [$];
  logic [SUMW-1:0] msum;
  logic            movf;

  task automatic step(input logic iv, input logic [N-1:0] res,
                      input logic ordy, input logic r);
    int  c;
    bit  p;
    bit  pp;
    c = cyc;
    hv[c]   = iv;
    hr[c]   = res;
    hrst[c] = r;
    in_valid  = iv;
    out_ready = ordy;
    rst       = r;
    p = 0;
    if (c >= 3 && hv[c-3]) begin
      F = hr[c-3];
      p = !hrst[c-3] && !hrst[c-2] && !hrst[c-1] && !r;
    end else begin
      F = N'($urandom);
    end
    if (r) begin
      mq.delete();
      msum = '0;
      movf = 1'b0;
    end else begin
      pp = (mq.size() > 0) && ordy;
      if (p && mq.size() == DEPTH && !pp) begin
        movf = 1'b1;
      end else if (p) begin
        if (pp) void'(mq.pop_front());
        mq.push_back(F);
        msum = msum + SUMW'(F);
        pp = 0;
      end
      if (pp) void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, N'($urandom), ordy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, N'($urandom), 1'b0, 1'b1);
    step(1'b1, N'($urandom), 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, N'($urandom), 1'(($urandom)), 1'b1);
    step(1'b1, N'($urandom), 1'(($urandom)), 1'b1);
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || sum !== '0
        || overflow !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset: v=%b cnt=%0d sum=%0d ovf=%b data=%0d required all 0",
               out_valid, count, sum, overflow, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 10'd75, 1'b0, 1'b0);
    idle(2, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: out_valid=%b required 0", out_valid);
    end
    idle(1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'd75) begin
      errors++;
      $display("FAIL single_data: v=%b data=%0d required 1/75",
               out_valid, out_data);
    end
    checks++;
    if (count !== 3'd1 || sum !== 18'd75) begin
      errors++;
      $display("FAIL single_cnt: cnt=%0d sum=%0d required 1/75", count, sum);
    end
  endtask

  task automatic test_fill_overflow_drain();
    logic [N-1:0] exp [4];
    exp[0] = 10'd75;
    exp[1] = 10'd66;
    exp[2] = 10'd112;
    exp[3] = 10'd62;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, exp[i], 1'b0, 1'b0);
    step(1'b1, 10'd0, 1'b0, 1'b0);
    step(1'b1, 10'd66, 1'b0, 1'b0);
    idle(1, 1'b0);
    checks++;
    if (count !== 3'd4 || sum !== 18'd315 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: cnt=%0d sum=%0d ovf=%b required 4/315/0",
               count, sum, overflow);
    end
    idle(1, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_first: ovf=%b required 1", overflow);
    end
    idle(1, 1'b0);
    checks++;
    if (count !== 3'd4 || sum !== 18'd315 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: cnt=%0d sum=%0d ovf=%b required 4/315/1",
               count, sum, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL drain_%0d: v=%b data=%0d required 1/%0d",
                 i, out_valid, out_data, exp[i]);
      end
      idle(1, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || count !== 3'd0
        || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: v=%b data=%0d cnt=%0d ovf=%b required 0/0/0/1",
               out_valid, out_data, count, overflow);
    end
    idle(1, 1'b1);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop: cnt=%0d v=%b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_push_pop_full();
    logic [N-1:0] exp [4];
    exp[0] = 10'd66;
    exp[1] = 10'd112;
    exp[2] = 10'd62;
    exp[3] = 10'd66;
    do_reset();
    step(1'b1, 10'd75, 1'b0, 1'b0);
    step(1'b1, 10'd66, 1'b0, 1'b0);
    step(1'b1, 10'd112, 1'b0, 1'b0);
    step(1'b1, 10'd62, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 10'd66, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    checks++;
    if (count !== 3'd4 || sum !== 18'd381 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ppfull: cnt=%0d sum=%0d ovf=%b required 4/381/0",
               count, sum, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== exp[i]) begin
        errors++;
        $display("FAIL ppfull_drain_%0d: data=%0d required %0d",
                 i, out_data, exp[i]);
      end
      idle(1, 1'b1);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    step(1'b1, 10'd99, 1'b0, 1'b0);
    step(1'b0, N'($urandom), 1'b0, 1'b1);
    idle(3, 1'b0);
    checks++;
    if (count !== 3'd0 || sum !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst: cnt=%0d sum=%0d v=%b required 0/0/0",
               count, sum, out_valid);
    end
    step(1'b1, 10'd33, 1'b0, 1'b0);
    idle(2, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: v=%b required 0", out_valid);
    end
    idle(1, 1'b0);
    checks++;
    if (count !== 3'd1 || out_data !== 10'd33 || sum !== 18'd33) begin
      errors++;
      $display("FAIL midrst_new: cnt=%0d data=%0d sum=%0d required 1/33/33",
               count, out_data, sum);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ed;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom), N'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 79) == 0));
      ed = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== ed) begin
        errors++;
        $display("FAIL rand_head @%0d: v=%b data=%0d required %b/%0d",
                 i, out_valid, out_data, (mq.size() > 0), ed);
      end
      checks++;
      if (count !== 3'(mq.size()) || sum !== msum
          || overflow !== movf) begin
        errors++;
        $display("FAIL rand_state @%0d: cnt=%0d sum=%0d ovf=%b required %0d/%0d/%b",
                 i, count, sum, overflow, mq.size(), msum, movf);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    msum      = '0;
    movf      = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    F         = '0;
    test_reset();
    test_single();
    test_fill_overflow_drain();
    test_push_pop_full();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
